// File: rtl/ni_rx_depacketizer.sv
// ---------------------------------------------------------------------------
// ni_rx_depacketizer
// Receive-side network interface between a router output port and a neuron
// core. Incoming flits are buffered in one show-ahead FIFO per virtual
// channel. A single VC is granted for a whole packet. Head/body/tail flits
// are reassembled into a NUM_NURNS-bit spike vector plus header fields.
// Every popped flit returns one credit on its VC.
//
// Optional feature: define NI_RR_ARB_EN for round-robin VC arbitration.
// When it is undefined, the lowest-index non-empty VC wins.
//
// Ports:
//   router_clk    clock, rising edge
//   router_rst    asynchronous active-low reset
//   flit_in_wr    flit_in valid this cycle
//   flit_in       {kind[1:0], one-hot vc[VIRTUAL_CHANNEL-1:0], payload[31:0]}
//   credit_out    one-cycle credit pulse per popped flit, per VC
//   pkt_valid     reassembled packet available (held until pkt_ready)
//   pkt_ready     consumer accepts the packet
//   pkt_type      head payload [31:29]
//   pkt_src_x     head payload [2*AW-1:AW]
//   pkt_src_y     head payload [AW-1:0]
//   spike_vector  reassembled payload, first data word in [31:0]
//   len_err       with pkt_valid: data-word count differs from NUM_NURNS/32
//   proto_err     one-cycle pulse on a protocol violation
//   overflow_err  sticky flag: a flit was written to a full FIFO
// ---------------------------------------------------------------------------
module ni_rx_depacketizer #(
  parameter int VIRTUAL_CHANNEL = 4,
  parameter int ADDRESS_WIDTH   = 5,
  parameter int NUM_NURNS       = 128,
  parameter int FIFO_AW         = 3
) (
  input  logic                         router_clk,
  input  logic                         router_rst,
  input  logic                         flit_in_wr,
  input  logic [VIRTUAL_CHANNEL+33:0]  flit_in,
  output logic [VIRTUAL_CHANNEL-1:0]   credit_out,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic [2:0]                   pkt_type,
  output logic [ADDRESS_WIDTH-1:0]     pkt_src_x,
  output logic [ADDRESS_WIDTH-1:0]     pkt_src_y,
  output logic [NUM_NURNS-1:0]         spike_vector,
  output logic                         len_err,
  output logic                         proto_err,
  output logic                         overflow_err
);

  localparam int FLIT_WIDTH = 2 + VIRTUAL_CHANNEL + 32;
  localparam int WORDS      = NUM_NURNS / 32;
  localparam int DEPTH      = 1 << FIFO_AW;
  localparam int CNT_W      = $clog2(WORDS + 2);
  localparam int VC_W       = (VIRTUAL_CHANNEL > 1) ? $clog2(VIRTUAL_CHANNEL) : 1;

  localparam logic [1:0] K_BODY   = 2'b00;
  localparam logic [1:0] K_TAIL   = 2'b01;
  localparam logic [1:0] K_HEAD   = 2'b10;
  localparam logic [1:0] K_SINGLE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_OUT} state_t;

  // Storage keeps only kind + payload; the VC field is implied by the FIFO.
  logic [33:0]                 mem_q [VIRTUAL_CHANNEL][DEPTH];
  logic [FIFO_AW:0]            wptr_q [VIRTUAL_CHANNEL];
  logic [FIFO_AW:0]            rptr_q [VIRTUAL_CHANNEL];
  logic [VIRTUAL_CHANNEL-1:0]  empty, full, push, pop;
  logic [VIRTUAL_CHANNEL-1:0]  wr_vc;
  logic                        wr_onehot, bad_vc, ovf_set, do_pop;
  logic [1:0]                  rd_kind;
  logic [31:0]                 rd_pay;

  state_t                      state_q, state_d;
  logic [VC_W-1:0]             vc_sel_q, vc_sel_d, grant;
  logic                        got_head_q, got_head_d, perr_rx;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [NUM_NURNS-1:0]        shift_q, shift_d, shifted;
  logic [2:0]                  type_q, type_d;
  logic [ADDRESS_WIDTH-1:0]    srcx_q, srcx_d, srcy_q, srcy_d;
  logic [NUM_NURNS-1:0]        spike_q, spike_d;
  logic                        len_err_q, len_err_d;
  logic [VIRTUAL_CHANNEL-1:0]  credit_q;
  logic                        proto_q, ovf_q;
`ifdef NI_RR_ARB_EN
  logic [VC_W-1:0]             rr_q, rr_d;
`endif

  // Insert a payload word at the top, moving older words toward [31:0].
  function automatic logic [NUM_NURNS-1:0] shift_in(input logic [NUM_NURNS-1:0] s,
                                                    input logic [31:0] p);
    logic [NUM_NURNS-1:0] r;
    r = s >> 32;
    r[NUM_NURNS-1 -: 32] = p;
    return r;
  endfunction

  // A short packet leaves its words at the top of the shifter; move them down
  // so the first data word always lands in [31:0].
  function automatic logic [NUM_NURNS-1:0] align(input logic [NUM_NURNS-1:0] s,
                                                 input logic [CNT_W-1:0] c);
    logic [NUM_NURNS-1:0] r;
    int off;
    r   = '0;
    off = (int'(c) >= WORDS) ? 0 : WORDS - int'(c);
    for (int w = 0; w < WORDS; w++)
      if (w + off < WORDS) r[w*32 +: 32] = s[(w+off)*32 +: 32];
    return r;
  endfunction

  always_comb begin
    for (int v = 0; v < VIRTUAL_CHANNEL; v++) begin
      empty[v] = (wptr_q[v] == rptr_q[v]);
      full[v]  = (wptr_q[v][FIFO_AW] != rptr_q[v][FIFO_AW]) &&
                 (wptr_q[v][FIFO_AW-1:0] == rptr_q[v][FIFO_AW-1:0]);
    end
  end

  always_comb begin
    pop = '0;
    if (state_q == S_RECV && !empty[vc_sel_q]) pop[vc_sel_q] = 1'b1;
    do_pop  = |pop;
    rd_kind = mem_q[vc_sel_q][rptr_q[vc_sel_q][FIFO_AW-1:0]][33:32];
    rd_pay  = mem_q[vc_sel_q][rptr_q[vc_sel_q][FIFO_AW-1:0]][31:0];
  end

  // A full FIFO still accepts a write when it is popped in the same cycle.
  always_comb begin
    wr_vc     = flit_in[32 +: VIRTUAL_CHANNEL];
    wr_onehot = (wr_vc != '0) && ((wr_vc & (wr_vc - VIRTUAL_CHANNEL'(1))) == '0);
    push      = '0;
    ovf_set   = 1'b0;
    if (flit_in_wr && wr_onehot) begin
      push    = wr_vc & (~full | pop);
      ovf_set = |(wr_vc & full & ~pop);
    end
    bad_vc = flit_in_wr && !wr_onehot;
  end

  always_comb begin
    grant = '0;
`ifdef NI_RR_ARB_EN
    begin
      logic found;
      int   idx;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < VIRTUAL_CHANNEL; i++) begin
        idx = (int'(rr_q) + 1 + i) % VIRTUAL_CHANNEL;
        if (!found && !empty[idx]) begin
          grant = VC_W'(idx);
          found = 1'b1;
        end
      end
    end
`else
    for (int i = VIRTUAL_CHANNEL - 1; i >= 0; i--)
      if (!empty[i]) grant = VC_W'(i);
`endif
  end

  always_comb begin
    state_d    = state_q;
    vc_sel_d   = vc_sel_q;
    got_head_d = got_head_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    type_d     = type_q;
    srcx_d     = srcx_q;
    srcy_d     = srcy_q;
    spike_d    = spike_q;
    len_err_d  = len_err_q;
    perr_rx    = 1'b0;
`ifdef NI_RR_ARB_EN
    rr_d       = rr_q;
`endif
    cnt_inc = (cnt_q == CNT_W'(WORDS + 1)) ? cnt_q : cnt_q + CNT_W'(1);
    shifted = shift_in(shift_q, rd_pay);
    unique case (state_q)
      S_IDLE: begin
        if (|(~empty)) begin
          state_d    = S_RECV;
          vc_sel_d   = grant;
          got_head_d = 1'b0;
`ifdef NI_RR_ARB_EN
          rr_d       = grant;
`endif
        end
      end
      S_RECV: begin
        if (do_pop) begin
          unique case (rd_kind)
            K_HEAD, K_SINGLE: begin
              perr_rx = got_head_q;
              type_d  = rd_pay[31:29];
              srcx_d  = rd_pay[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH];
              srcy_d  = rd_pay[ADDRESS_WIDTH-1:0];
              if (rd_kind == K_HEAD) begin
                shift_d    = '0;
                cnt_d      = '0;
                got_head_d = 1'b1;
              end else begin
                shift_d    = shift_in('0, rd_pay);
                cnt_d      = CNT_W'(1);
                spike_d    = align(shift_in('0, rd_pay), CNT_W'(1));
                len_err_d  = (WORDS != 1);
                got_head_d = 1'b0;
                state_d    = S_OUT;
              end
            end
            K_BODY, K_TAIL: begin
              if (!got_head_q) begin
                // Orphan flit: drop it and release the grant.
                perr_rx = 1'b1;
                state_d = S_IDLE;
              end else begin
                shift_d = shifted;
                cnt_d   = cnt_inc;
                if (rd_kind == K_TAIL) begin
                  spike_d    = align(shifted, cnt_inc);
                  len_err_d  = (cnt_inc != CNT_W'(WORDS));
                  got_head_d = 1'b0;
                  state_d    = S_OUT;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_OUT: begin
        if (pkt_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge router_clk) begin
    for (int v = 0; v < VIRTUAL_CHANNEL; v++)
      if (push[v]) mem_q[v][wptr_q[v][FIFO_AW-1:0]] <= {flit_in[FLIT_WIDTH-1 -: 2], flit_in[31:0]};
  end

  always_ff @(posedge router_clk or negedge router_rst) begin
    if (!router_rst) begin
      for (int v = 0; v < VIRTUAL_CHANNEL; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
      end
      state_q    <= S_IDLE;
      vc_sel_q   <= '0;
      got_head_q <= 1'b0;
      cnt_q      <= '0;
      shift_q    <= '0;
      type_q     <= '0;
      srcx_q     <= '0;
      srcy_q     <= '0;
      spike_q    <= '0;
      len_err_q  <= 1'b0;
      credit_q   <= '0;
      proto_q    <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef NI_RR_ARB_EN
      rr_q       <= '0;
`endif
    end else begin
      for (int v = 0; v < VIRTUAL_CHANNEL; v++) begin
        if (push[v]) wptr_q[v] <= wptr_q[v] + 1'b1;
        if (pop[v])  rptr_q[v] <= rptr_q[v] + 1'b1;
      end
      state_q    <= state_d;
      vc_sel_q   <= vc_sel_d;
      got_head_q <= got_head_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      type_q     <= type_d;
      srcx_q     <= srcx_d;
      srcy_q     <= srcy_d;
      spike_q    <= spike_d;
      len_err_q  <= len_err_d;
      credit_q   <= pop;
      proto_q    <= bad_vc | perr_rx;
      ovf_q      <= ovf_q | ovf_set;
`ifdef NI_RR_ARB_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign credit_out   = credit_q;
  assign pkt_valid    = (state_q == S_OUT);
  assign pkt_type     = type_q;
  assign pkt_src_x    = srcx_q;
  assign pkt_src_y    = srcy_q;
  assign spike_vector = spike_q;
  assign len_err      = len_err_q;
  assign proto_err    = proto_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_ni_rx_depacketizer.sv
module tb_ni_rx_depacketizer;
  localparam int VC = 4;
  localparam int AW = 5;
  localparam int NN = 128;
  localparam int FW = 2 + VC + 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic [FW-1:0] flit = '0;
  logic          rdy = 1'b0;
  logic [VC-1:0] credit_out;
  logic          pkt_valid, len_err, proto_err, overflow_err;
  logic [2:0]    pkt_type;
  logic [AW-1:0] pkt_src_x, pkt_src_y;
  logic [NN-1:0] spike_vector;

  int passed = 0;
  int total  = 0;
  int cred_cnt [VC];

  ni_rx_depacketizer #(.VIRTUAL_CHANNEL(VC), .ADDRESS_WIDTH(AW), .NUM_NURNS(NN), .FIFO_AW(3)) dut (
    .router_clk(clk), .router_rst(rst_n), .flit_in_wr(wr), .flit_in(flit),
    .credit_out(credit_out), .pkt_valid(pkt_valid), .pkt_ready(rdy),
    .pkt_type(pkt_type), .pkt_src_x(pkt_src_x), .pkt_src_y(pkt_src_y),
    .spike_vector(spike_vector), .len_err(len_err), .proto_err(proto_err),
    .overflow_err(overflow_err));

  always #5 clk = ~clk;

  initial for (int v = 0; v < VC; v++) cred_cnt[v] = 0;
  always @(negedge clk)
    for (int v = 0; v < VC; v++) if (credit_out[v] === 1'b1) cred_cnt[v]++;

  task automatic chk(input string tag, input logic [NN-1:0] obs, input logic [NN-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] k, input logic [VC-1:0] v, input logic [31:0] p);
    wr   = 1'b1;
    flit = {k, v, p};
    step();
    wr   = 1'b0;
    flit = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (pkt_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, pkt_valid, 1);
  endtask

  task automatic accept();
    rdy = 1'b1;
    step();
    rdy = 1'b0;
  endtask

  logic [NN-1:0] exp_vec;
  logic [31:0]   ord [3];
  int            c0, nv;

  initial begin
    // Reset state
    step();
    step();
    chk("rst_valid", pkt_valid, 0);
    chk("rst_credit", credit_out, 0);
    chk("rst_spike", spike_vector, 0);
    chk("rst_errs", {len_err, proto_err, overflow_err}, 0);
    rst_n = 1'b1;
    step();

    // Single flit on VC0: written cycle 0, visible at cycle 3
    put(2'b11, 4'b0001, 32'h0000_A5A5);
    step();
    chk("single_early", pkt_valid, 0);
    step();
    chk("single_valid", pkt_valid, 1);
    chk("single_credit", credit_out, 4'b0001);
    chk("single_spike", spike_vector, 128'h0000_A5A5);
    chk("single_len_err", len_err, 1);
    chk("single_type", pkt_type, 0);
    chk("single_src_x", pkt_src_x, 13);
    chk("single_src_y", pkt_src_y, 5);
    accept();
    chk("single_done", pkt_valid, 0);

    // Head + 3 bodies + tail on VC2, consumer stalls 5 cycles
    c0 = cred_cnt[2];
    put(2'b10, 4'b0100, 32'hA000_00E9);
    put(2'b00, 4'b0100, 32'd1);
    put(2'b00, 4'b0100, 32'd2);
    put(2'b00, 4'b0100, 32'd3);
    put(2'b01, 4'b0100, 32'd4);
    wait_valid("multi_valid");
    exp_vec = 128'h00000004_00000003_00000002_00000001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("multi_hold_valid", pkt_valid, 1);
      chk("multi_hold_spike", spike_vector, exp_vec);
    end
    chk("multi_len_err", len_err, 0);
    chk("multi_type", pkt_type, 3'b101);
    chk("multi_src_x", pkt_src_x, 7);
    chk("multi_src_y", pkt_src_y, 9);
    accept();
    step();
    chk("multi_done", pkt_valid, 0);
    chk("multi_credits", cred_cnt[2] - c0, 5);

    // Bad VC fields are dropped with a proto_err pulse
    put(2'b11, 4'b0011, 32'h1);
    chk("badvc_multi_pulse", proto_err, 1);
    step();
    chk("badvc_pulse_end", proto_err, 0);
    put(2'b11, 4'b0000, 32'h1);
    chk("badvc_zero_pulse", proto_err, 1);
    step();

    // Orphan body flit: discarded with one credit, no packet
    c0 = cred_cnt[2];
    put(2'b00, 4'b0100, 32'h55);
    step();
    step();
    chk("orphan_proto", proto_err, 1);
    chk("orphan_credit", credit_out, 4'b0100);
    step();
    chk("orphan_proto_end", proto_err, 0);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (pkt_valid === 1'b1) nv++;
      step();
    end
    chk("orphan_no_valid", nv, 0);
    chk("orphan_credits", cred_cnt[2] - c0, 1);

    // Arbitration: VC1 holds two packets, VC3 one, all queued behind a VC0 packet
    put(2'b11, 4'b0001, 32'h11);
    step();
    step();
    chk("arb_block_valid", pkt_valid, 1);
    put(2'b10, 4'b0010, 32'h1);
    put(2'b01, 4'b0010, 32'hA1);
    put(2'b10, 4'b0010, 32'h2);
    put(2'b01, 4'b0010, 32'hB1);
    put(2'b10, 4'b1000, 32'h3);
    put(2'b01, 4'b1000, 32'hC3);
    chk("arb_block_spike", spike_vector, 128'h11);
    accept();
`ifdef NI_RR_ARB_EN
    ord[0] = 32'hA1; ord[1] = 32'hC3; ord[2] = 32'hB1;
`else
    ord[0] = 32'hA1; ord[1] = 32'hB1; ord[2] = 32'hC3;
`endif
    for (int i = 0; i < 3; i++) begin
      wait_valid("arb_valid");
      chk("arb_order", spike_vector, {96'h0, ord[i]});
      chk("arb_src_y", pkt_src_y, (ord[i] == 32'hA1) ? 5'd1 : (ord[i] == 32'hB1) ? 5'd2 : 5'd3);
      chk("arb_len_err", len_err, 1);
      accept();
    end

    // Reset in the middle of a packet (head + 2 bodies popped)
    step();
    step();
    put(2'b10, 4'b0001, 32'h0);
    put(2'b00, 4'b0001, 32'h10);
    put(2'b00, 4'b0001, 32'h20);
    put(2'b00, 4'b0001, 32'h30);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", pkt_valid, 0);
    chk("midrst_credit", credit_out, 0);
    step();
    rst_n = 1'b1;
    c0 = cred_cnt[0];
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      if (pkt_valid === 1'b1) nv++;
      step();
    end
    chk("midrst_fifo_empty", cred_cnt[0] - c0, 0);
    chk("midrst_no_valid", nv, 0);
    put(2'b11, 4'b1000, 32'h1234_0021);
    step();
    step();
    chk("postrst_valid", pkt_valid, 1);
    chk("postrst_credit", credit_out, 4'b1000);
    chk("postrst_spike", spike_vector, 128'h1234_0021);
    chk("postrst_src", {pkt_type, pkt_src_x, pkt_src_y}, {3'b000, 5'd1, 5'd1});
    accept();

    // Overflow: 9 writes to VC0 while the FSM is parked in OUT on VC1
    put(2'b11, 4'b0010, 32'h77);
    step();
    step();
    chk("ovf_block_valid", pkt_valid, 1);
    for (int i = 1; i <= 8; i++) put(2'b11, 4'b0001, 32'(i));
    chk("ovf_before", overflow_err, 0);
    put(2'b11, 4'b0001, 32'd9);
    chk("ovf_after", overflow_err, 1);
    chk("ovf_block_spike", spike_vector, 128'h77);
    accept();
    for (int i = 1; i <= 8; i++) begin
      wait_valid("ovf_drain_valid");
      chk("ovf_drain_spike", spike_vector, NN'(i));
      accept();
    end
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (pkt_valid === 1'b1) nv++;
      step();
    end
    chk("ovf_ninth_dropped", nv, 0);
    chk("ovf_sticky", overflow_err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
